// File: rtl/qr_feeder_pkg.sv
// Shared types and sizing for the QR core feeder.
// Row layout and FSM states used by qr_feeder and qr_row_buf.
package qr_feeder_pkg;

  localparam int DW      = 13;
  localparam int N_IN    = 9;
  localparam int N_OUT   = 8;
  localparam int TIMEOUT = 100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_COLLECT,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic                 last_end;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic signed [DW-1:0] c;
    logic signed [DW-1:0] d;
  } row_t;

endpackage

// File: rtl/qr_row_buf.sv
// Simple row store: one write port, one read port whose
// address is registered, so data follows the address by one edge.
module qr_row_buf #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0]  mem_q [1<<AW];
  logic [AW-1:0] raddr_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) raddr_q <= '0;
    else        raddr_q <= raddr_i;
  end

  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/qr_feeder.sv
// Buffers one matrix from the host, streams it into the QR core,
// captures the result rows and lets the host drain them.
module qr_feeder #(
  parameter int N_IN    = qr_feeder_pkg::N_IN,
  parameter int N_OUT   = qr_feeder_pkg::N_OUT,
  parameter int TIMEOUT = qr_feeder_pkg::TIMEOUT,
  parameter int DW      = qr_feeder_pkg::DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic                 ld_last_end,
  input  logic signed [DW-1:0] ld_A,
  input  logic signed [DW-1:0] ld_B,
  input  logic signed [DW-1:0] ld_C,
  input  logic signed [DW-1:0] ld_D,
  output logic signed [DW-1:0] qr_A,
  output logic signed [DW-1:0] qr_B,
  output logic signed [DW-1:0] qr_C,
  output logic signed [DW-1:0] qr_D,
  output logic                 qr_last_end,
  input  logic                 qr_value,
  input  logic signed [DW-1:0] qr_out_A,
  input  logic signed [DW-1:0] qr_out_B,
  input  logic signed [DW-1:0] qr_out_C,
  input  logic signed [DW-1:0] qr_out_D,
  input  logic                 qr_valid,
  input  logic                 qr_finish,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic signed [DW-1:0] rd_A,
  output logic signed [DW-1:0] rd_B,
  output logic signed [DW-1:0] rd_C,
  output logic signed [DW-1:0] rd_D,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 err_overflow
);

  import qr_feeder_pkg::*;

  localparam int IW = $clog2(N_IN + 1);
  localparam int OW = $clog2(N_OUT + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] NI      = IW'(N_IN);
  localparam logic [IW-1:0] NI_LAST = IW'(N_IN - 1);
  localparam logic [OW-1:0] NO      = OW'(N_OUT);
  localparam logic [CW-1:0] TO      = CW'(TIMEOUT);

  state_t          state_q, state_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [OW-1:0]   cap_q, cap_d;
  logic [OW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  row_t            qr_q, qr_d;
  row_t            ld_row, in_row;
  logic [4*DW-1:0] out_row;
  logic            done_q, done_d;
  logic            err_to_q, err_to_d;
  logic            err_ov_q, err_ov_d;
  logic            active, ld_fire, feed_fire, cap_fire;

  assign ld_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign ld_fire   = ld_valid && ld_ready;
  assign active    = (state_q == S_FEED) || (state_q == S_COLLECT);
  assign feed_fire = (state_q == S_FEED) && qr_value && (rd_idx_q < NI);
  assign cap_fire  = active && qr_valid && (cap_q < NO);
  assign ld_row    = {ld_last_end, ld_A, ld_B, ld_C, ld_D};

  qr_row_buf #(.W($bits(row_t)), .DEPTH(N_IN)) u_in_buf (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (ld_fire),
    .waddr_i (wr_idx_q),
    .wdata_i (ld_row),
    .raddr_i (rd_idx_d),
    .rdata_o (in_row)
  );

  qr_row_buf #(.W(4*DW), .DEPTH(N_OUT)) u_out_buf (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (cap_fire),
    .waddr_i (cap_q),
    .wdata_i ({qr_out_A, qr_out_B, qr_out_C, qr_out_D}),
    .raddr_i (rd_ptr_d),
    .rdata_o (out_row)
  );

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cap_d    = cap_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_to_d = err_to_q;
    err_ov_d = err_ov_q;
    // A tagged last row stays on the core bus; anything else idles at zero.
    qr_d     = qr_q.last_end ? qr_q : '0;
    if (feed_fire) begin
      qr_d     = in_row;
      rd_idx_d = rd_idx_q + 1'b1;
    end
    if (cap_fire) cap_d = cap_q + 1'b1;
    if (active && qr_valid && (cap_q == NO)) err_ov_d = 1'b1;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (ld_fire) begin
          wr_idx_d = wr_idx_q + 1'b1;
          if (state_q == S_IDLE) begin
            err_to_d = 1'b0;
            err_ov_d = 1'b0;
            state_d  = S_LOAD;
          end
          if (wr_idx_q == NI_LAST) begin
            state_d  = S_FEED;
            rd_idx_d = '0;
            cnt_d    = '0;
          end
        end
      end
      S_FEED, S_COLLECT: begin
        cnt_d = cnt_q + 1'b1;
        if (feed_fire && (rd_idx_q == NI_LAST)) state_d = S_COLLECT;
        if (qr_finish) begin
          state_d = S_DRAIN;
        end else if (cnt_d == TO) begin
          err_to_d = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_ptr_q < cap_q) begin
          if (rd_ready) rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
          done_d   = 1'b1;
          wr_idx_d = '0;
          rd_idx_d = '0;
          cap_d    = '0;
          rd_ptr_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cap_q    <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      qr_q     <= '0;
      done_q   <= 1'b0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cap_q    <= cap_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      qr_q     <= qr_d;
      done_q   <= done_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
    end
  end

  assign qr_A         = qr_q.a;
  assign qr_B         = qr_q.b;
  assign qr_C         = qr_q.c;
  assign qr_D         = qr_q.d;
  assign qr_last_end  = qr_q.last_end;
  assign rd_valid     = (state_q == S_DRAIN) && (rd_ptr_q < cap_q);
  assign rd_A         = out_row[4*DW-1 -: DW];
  assign rd_B         = out_row[3*DW-1 -: DW];
  assign rd_C         = out_row[2*DW-1 -: DW];
  assign rd_D         = out_row[DW-1 -: DW];
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err_timeout  = err_to_q;
  assign err_overflow = err_ov_q;

endmodule

// File: tb/tb_qr_feeder.sv
// Scoreboard bench for qr_feeder: stimulus queues expected core-bus
// and drain rows, a negedge monitor pops and compares them.
module tb_qr_feeder;

  localparam int DW = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic ld_valid, ld_ready, ld_last_end;
  logic signed [DW-1:0] ld_A, ld_B, ld_C, ld_D;
  logic signed [DW-1:0] qr_A, qr_B, qr_C, qr_D;
  logic qr_last_end, qr_value;
  logic signed [DW-1:0] qr_out_A, qr_out_B, qr_out_C, qr_out_D;
  logic qr_valid, qr_finish;
  logic rd_valid, rd_ready;
  logic signed [DW-1:0] rd_A, rd_B, rd_C, rd_D;
  logic busy, done, err_timeout, err_overflow;

  qr_feeder dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_last_end(ld_last_end),
    .ld_A(ld_A), .ld_B(ld_B), .ld_C(ld_C), .ld_D(ld_D),
    .qr_A(qr_A), .qr_B(qr_B), .qr_C(qr_C), .qr_D(qr_D),
    .qr_last_end(qr_last_end), .qr_value(qr_value),
    .qr_out_A(qr_out_A), .qr_out_B(qr_out_B),
    .qr_out_C(qr_out_C), .qr_out_D(qr_out_D),
    .qr_valid(qr_valid), .qr_finish(qr_finish),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_A(rd_A), .rd_B(rd_B), .rd_C(rd_C), .rd_D(rd_D),
    .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;
  logic [52:0] exp_qr[$];
  logic [51:0] exp_rd[$];
  logic [52:0] last_qr;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [52:0] in_row(input int k);
    logic [12:0] a, b, c, d;
    a = 13'(k);
    b = 13'(-k);
    c = 13'(100 + k);
    d = 13'(-4096 + k);
    return {(k == 8), a, b, c, d};
  endfunction

  function automatic logic [51:0] cap_row(input int i);
    int v;
    logic [12:0] a;
    case (i)
      0: v = 4095;
      1: v = -4096;
      2: v = 0;
      3: v = 1;
      4: v = -1;
      5: v = 2047;
      6: v = -2048;
      7: v = 7;
      default: v = 1234;
    endcase
    a = 13'(v);
    return {a, ~a, a ^ 13'h0A5, 13'(i)};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (exp_qr.size() > 0)
        chk("qr_row", 64'({qr_last_end, qr_A, qr_B, qr_C, qr_D}),
            64'(exp_qr.pop_front()));
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() > 0) begin
          chk("rd_row", 64'({rd_A, rd_B, rd_C, rd_D}),
              64'(exp_rd.pop_front()));
        end else begin
          n_vec++;
          n_err++;
          $display("FAIL rd_extra: got %0h expected none",
                   {rd_A, rd_B, rd_C, rd_D});
        end
      end
      if (done) begin
        done_cnt++;
        if (done_prev) begin
          n_vec++;
          n_err++;
          $display("FAIL done_width: got 2+ cycles expected 1");
        end
      end
    end
    done_prev <= done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_matrix();
    for (int k = 0; k < 9; k++) begin
      {ld_last_end, ld_A, ld_B, ld_C, ld_D} = in_row(k);
      ld_valid = 1'b1;
      tick();
    end
    ld_valid = 1'b0;
  endtask

  task automatic feed(input bit toggle, input int stop_at);
    int idx;
    int cyc;
    logic qv;
    idx = 0;
    cyc = 0;
    while (idx < stop_at) begin
      qv = toggle ? (cyc % 2 == 0) : 1'b1;
      qr_value = qv;
      tick();
      cyc++;
      if (qv) begin
        last_qr = in_row(idx);
        idx++;
      end else if (!last_qr[52]) begin
        last_qr = '0;
      end
      exp_qr.push_back(last_qr);
    end
    if (stop_at == 9) begin
      qr_value = 1'b1;
      repeat (2) begin
        tick();
        exp_qr.push_back(last_qr);
      end
    end
    qr_value = 1'b0;
  endtask

  task automatic emit(input int n, input bit fin_last, input bit fin_after);
    for (int i = 0; i < n; i++) begin
      qr_valid = 1'b1;
      {qr_out_A, qr_out_B, qr_out_C, qr_out_D} = cap_row(i);
      if (i < 8) exp_rd.push_back(cap_row(i));
      qr_finish = fin_last && (i == n - 1);
      tick();
    end
    qr_valid  = 1'b0;
    qr_finish = 1'b0;
    if (fin_after) begin
      qr_finish = 1'b1;
      tick();
      qr_finish = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    rd_ready = 1'b1;
    while (done_cnt == d0 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    rd_ready = 1'b0;
    chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    chk({nm, "_rd_left"}, 64'(exp_rd.size()), 64'(0));
    chk({nm, "_idle_busy"}, 64'(busy), 64'(0));
    chk({nm, "_idle_ld_ready"}, 64'(ld_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    reset = 1'b0;
    ld_valid = 1'b0; ld_last_end = 1'b0;
    ld_A = '0; ld_B = '0; ld_C = '0; ld_D = '0;
    qr_value = 1'b0; qr_valid = 1'b0; qr_finish = 1'b0;
    qr_out_A = '0; qr_out_B = '0; qr_out_C = '0; qr_out_D = '0;
    rd_ready = 1'b0;
    last_qr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld_ready", 64'(ld_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_errs", 64'({err_timeout, err_overflow}), 64'(0));
    chk("rst_qr", 64'({qr_last_end, qr_A, qr_B, qr_C, qr_D}), 64'(0));
    reset = 1'b1;
    tick();

    // A: full-rate feed, 8 results with finish on the last one
    load_matrix();
    chk("A_ld_ready_feed", 64'(ld_ready), 64'(0));
    chk("A_busy_feed", 64'(busy), 64'(1));
    feed(1'b0, 9);
    emit(8, 1'b1, 1'b0);
    chk("A_drain_rd_valid", 64'(rd_valid), 64'(1));
    drain("A");
    chk("A_errs", 64'({err_timeout, err_overflow}), 64'(0));

    // B: gapped feed, one result too many
    load_matrix();
    feed(1'b1, 9);
    emit(9, 1'b0, 1'b1);
    chk("B_overflow", 64'(err_overflow), 64'(1));
    drain("B");
    chk("B_overflow_sticky", 64'(err_overflow), 64'(1));

    // C: core never finishes
    load_matrix();
    chk("C_overflow_cleared", 64'(err_overflow), 64'(0));
    feed(1'b0, 9);
    emit(3, 1'b0, 1'b0);
    chk("C_no_early_timeout", 64'(err_timeout), 64'(0));
    n = 0;
    while (!err_timeout && n < 150) begin
      tick();
      n++;
    end
    chk("C_timeout_cycles", 64'(n), 64'(86));
    chk("C_timeout_busy", 64'(busy), 64'(1));
    drain("C");
    chk("C_timeout_sticky", 64'(err_timeout), 64'(1));

    // D: reset in the middle of feeding, then a clean matrix
    load_matrix();
    feed(1'b0, 4);
    @(negedge clk);
    #2;
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("D_rst_qr", 64'({qr_last_end, qr_A, qr_B, qr_C, qr_D}), 64'(0));
    chk("D_rst_busy", 64'(busy), 64'(0));
    chk("D_rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("D_rst_ld_ready", 64'(ld_ready), 64'(1));
    chk("D_rst_errs", 64'({err_timeout, err_overflow, done}), 64'(0));
    last_qr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    chk("D_no_done", 64'(done_cnt - d0), 64'(0));
    load_matrix();
    feed(1'b0, 9);
    emit(2, 1'b0, 1'b1);
    drain("D");
    chk("D_errs", 64'({err_timeout, err_overflow}), 64'(0));
    chk("qr_left", 64'(exp_qr.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
